// File: rtl/str_adc_packetizer_if.sv
// AXI4-Stream word channel between the packetizer and the PS stream RX port.
interface str_adc_packetizer_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/str_adc_packetizer.sv
// Packs a non-stallable 16-bit sample stream into fixed-length 32-bit AXI4-Stream packets,
// buffering in a local FIFO and counting words dropped when the FIFO is full.
module str_adc_packetizer #(
  parameter int DN      = 16,
  parameter int FIFO_AW = 9,
  parameter int LW      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DN-1:0]         sti_dat,
  input  logic                  sti_vld,
  input  logic                  ctl_start,
  input  logic                  ctl_stop,
  input  logic [LW-1:0]         cfg_len,
  output logic                  sts_run,
  output logic [31:0]           sts_ovf,
  str_adc_packetizer_if.master  m
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_n;
  logic                start_acc;
  logic                acc, word_done, word_last;

  logic [DN-1:0]       half_dat;
  logic                half_vld;
  logic [LW-1:0]       wcnt, len_m1;

  logic                pend, pend_last;
  logic [2*DN-1:0]     pend_dat;

  logic [2*DN:0]       mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    cnt;
  logic                full, wr, rd;

  assign acc       = sti_vld && (state != IDLE);
  assign word_done = acc && half_vld;
  assign word_last = (wcnt == len_m1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Stop in RUN exits at once only when sitting on a packet boundary.
  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    case (state)
      IDLE: if (ctl_start && !ctl_stop) begin
        state_n   = RUN;
        start_acc = 1'b1;
      end
      RUN: if (ctl_stop) begin
        if ((wcnt == '0 && !half_vld) || (word_done && word_last)) state_n = IDLE;
        else                                                     state_n = DRAIN;
      end
      DRAIN: if (word_done && word_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_dat  <= '0;
      half_vld  <= 1'b0;
      wcnt      <= '0;
      len_m1    <= '0;
      pend      <= 1'b0;
      pend_dat  <= '0;
      pend_last <= 1'b0;
      sts_ovf   <= '0;
    end else begin
      pend <= word_done;
      if (word_done) begin
        pend_dat  <= {sti_dat, half_dat};
        pend_last <= word_last;
      end
      if (start_acc) begin
        half_vld <= 1'b0;
        wcnt     <= '0;
        len_m1   <= (cfg_len == '0) ? '0 : cfg_len - LW'(1);
      end else if (acc) begin
        if (half_vld) begin
          half_vld <= 1'b0;
          wcnt     <= word_last ? '0 : wcnt + LW'(1);
        end else begin
          half_dat <= sti_dat;
          half_vld <= 1'b1;
        end
      end
      // A stray half sample must not leak into the next run.
      if (state != IDLE && state_n == IDLE) half_vld <= 1'b0;
      if (start_acc)
        sts_ovf <= '0;
      else if (pend && !wr && sts_ovf != '1)
        sts_ovf <= sts_ovf + 32'd1;
    end
  end

  assign full = (cnt == DEPTH[FIFO_AW:0]);
  assign rd   = m.tvalid && m.tready;
  assign wr   = pend && (!full || rd);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr, rd})
        2'b10:   cnt <= cnt + (FIFO_AW+1)'(1);
        2'b01:   cnt <= cnt - (FIFO_AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr] <= {pend_last, pend_dat};
  end

  // Head entry is never overwritten while it is still valid, so outputs hold under stall.
  assign m.tvalid = (cnt != '0);
  assign m.tdata  = m.tvalid ? mem[rd_ptr][2*DN-1:0] : '0;
  assign m.tlast  = m.tvalid ? mem[rd_ptr][2*DN] : 1'b0;
  assign m.tkeep  = 4'hF;
  assign sts_run  = (state != IDLE);

endmodule
